// File: rtl/input_buffer.sv
`timescale 1ns/1ps
// input_buffer: one-cycle registered stage for an image line and its template lines
module input_buffer #(
  parameter int PIXEL_SIZE    = 8,
  parameter int LINE_SIZE     = 16,
  parameter int NUM_TEMPLATES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [PIXEL_SIZE-1:0] I_in_line  [LINE_SIZE],
  input  logic [PIXEL_SIZE-1:0] T_in_line  [LINE_SIZE][NUM_TEMPLATES],
  output logic [PIXEL_SIZE-1:0] I_out_line [LINE_SIZE],
  output logic [PIXEL_SIZE-1:0] T_out_line [LINE_SIZE][NUM_TEMPLATES]
);
  for (genvar j = 0; j < LINE_SIZE; j++) begin : g_pix
    always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) I_out_line[j] <= '0;
      else        I_out_line[j] <= I_in_line[j];
    for (genvar k = 0; k < NUM_TEMPLATES; k++) begin : g_tpl
      always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) T_out_line[j][k] <= '0;
        else        T_out_line[j][k] <= T_in_line[j][k];
    end
  end
endmodule

// File: tb/tb_input_buffer.sv
`timescale 1ns/1ps
// tb_input_buffer: directed + random checks of the input_buffer one-cycle capture stage
module tb_input_buffer;
  localparam int PS = 8, LS = 16, NT = 4;
  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic [PS-1:0] I_in_line  [LS];
  logic [PS-1:0] T_in_line  [LS][NT];
  logic [PS-1:0] I_out_line [LS];
  logic [PS-1:0] T_out_line [LS][NT];
  logic [PS*LS-1:0]    exp_i;
  logic [PS*LS*NT-1:0] exp_t;
  int tests = 0;
  int fails = 0;

  input_buffer #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .I_in_line(I_in_line), .T_in_line(T_in_line),
    .I_out_line(I_out_line), .T_out_line(T_out_line)
  );

  always #3 CLK = ~CLK;

  function automatic logic [PS*LS-1:0] fi(input logic [PS-1:0] a [LS]);
    logic [PS*LS-1:0] r;
    for (int j = 0; j < LS; j++) r[j*PS +: PS] = a[j];
    return r;
  endfunction

  function automatic logic [PS*LS*NT-1:0] ft(input logic [PS-1:0] a [LS][NT]);
    logic [PS*LS*NT-1:0] r;
    for (int j = 0; j < LS; j++)
      for (int k = 0; k < NT; k++) r[(j*NT+k)*PS +: PS] = a[j][k];
    return r;
  endfunction

  task automatic check(input string tag);
    tests++;
    assert (fi(I_out_line) === exp_i) else begin
      fails++;
      $error("FAIL %s I_out_line got %h exp %h", tag, fi(I_out_line), exp_i);
    end
    tests++;
    assert (ft(T_out_line) === exp_t) else begin
      fails++;
      $error("FAIL %s T_out_line got %h exp %h", tag, ft(T_out_line), exp_t);
    end
  endtask

  task automatic check_px(input string tag, input logic [PS-1:0] got, input logic [PS-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, want);
    end
  endtask

  task automatic set_all(input logic [PS-1:0] v);
    for (int j = 0; j < LS; j++) begin
      I_in_line[j] = v;
      for (int k = 0; k < NT; k++) T_in_line[j][k] = v;
    end
  endtask

  task automatic set_rand();
    for (int j = 0; j < LS; j++) begin
      I_in_line[j] = 8'($urandom_range(0, 255));
      for (int k = 0; k < NT; k++) T_in_line[j][k] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic set_index();
    for (int j = 0; j < LS; j++) begin
      I_in_line[j] = 8'(j);
      for (int k = 0; k < NT; k++) T_in_line[j][k] = 8'(16*j + k);
    end
  endtask

  // Reference model: a line driven before an edge with reset released is what the outputs must show after it.
  task automatic cycle(input string tag, input bit decoy);
    @(posedge CLK);
    if (RST_N) begin
      exp_i = fi(I_in_line);
      exp_t = ft(T_in_line);
    end
    #1;
    if (decoy) begin
      set_rand();
      check({tag, "_mid"});
    end
    @(negedge CLK);
    check(tag);
  endtask

  initial begin
    set_all(8'hFF);
    exp_i = '0;
    exp_t = '0;
    #1 RST_N = 1'b0;
    #1 check("reset_async");
    repeat (3) cycle("reset_hold", 1'b0);
    set_all(8'h00);
    #1 RST_N = 1'b1;
    cycle("release", 1'b0);
    I_in_line[0]    = 8'd37;
    T_in_line[3][2] = 8'd200;
    #1 check("latency_before");
    check_px("latency_before_i0", I_out_line[0], 8'd0);
    cycle("latency_after", 1'b0);
    check_px("latency_i0", I_out_line[0], 8'd37);
    check_px("latency_t32", T_out_line[3][2], 8'd200);
    repeat (10) begin
      set_rand();
      cycle("stream", 1'b1);
    end
    set_index();
    cycle("index", 1'b0);
    check_px("index_i5", I_out_line[5], 8'd5);
    check_px("index_t3_2", T_out_line[3][2], 8'd50);
    check_px("index_t2_3", T_out_line[2][3], 8'd35);
    set_all(8'hAA);
    cycle("pre_aa", 1'b0);
    #1 RST_N = 1'b0;
    exp_i = '0;
    exp_t = '0;
    #1 check("async_clear");
    set_rand();
    cycle("reset_low", 1'b0);
    set_rand();
    #1 RST_N = 1'b1;
    cycle("first_capture", 1'b0);
    set_rand();
    repeat (5) cycle("hold", 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
